// File: rtl/rst_sequencer.sv
// Reset release sequencer: qualifies PLL lock, then releases downstream
// resets one stage at a time with fixed spacing. Handles lock loss and
// software reset requests by reasserting every stage.
module rst_sequencer #(
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned STAGE_DELAY   = 16,
  parameter int unsigned LOCK_STABLE   = 64,
  parameter int unsigned SW_RST_CYCLES = 8,
  parameter int unsigned USE_LOCK      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic                  sw_rst_req,
  input  logic                  clr_lock_lost,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic                  lock_lost
);

  localparam int unsigned MAX_AB    = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
  localparam int unsigned MAX_DELAY = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
  localparam int unsigned CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STAGGER   = 2'd1,
    RUN       = 2'd2,
    SW_HOLD   = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [NUM_STAGES-1:0]   rst_out_n;
  logic                    ready_n;
  logic                    lock_lost_n;
  logic                    lock_lost_set;
  logic [1:0]              lock_sync;
  logic                    lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
    end
  end

  // Without lock monitoring the lock is treated as permanently good
  assign lock_s = (USE_LOCK != 0) ? lock_sync[1] : 1'b1;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      rst_out   <= '1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      rst_out   <= rst_out_n;
      ready     <= ready_n;
      lock_lost <= lock_lost_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    idx_n         = idx;
    rst_out_n     = rst_out;
    ready_n       = ready;
    lock_lost_set = 1'b0;

    case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_n = '0;
        end else if (cnt == LOCK_LAST) begin
          state_n = STAGGER;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STAGGER, RUN: begin
        if (!lock_s) begin
          // Lock loss outranks a simultaneous software request
          state_n       = WAIT_LOCK;
          cnt_n         = '0;
          idx_n         = '0;
          rst_out_n     = '1;
          ready_n       = 1'b0;
          lock_lost_set = 1'b1;
        end else if (sw_rst_req) begin
          state_n   = SW_HOLD;
          cnt_n     = '0;
          idx_n     = '0;
          rst_out_n = '1;
          ready_n   = 1'b0;
        end else if (state == STAGGER) begin
          if (cnt == STAGE_LAST) begin
            cnt_n = '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (IDX_W'(k) == idx) begin
                rst_out_n[k] = 1'b0;
              end
            end
            if (idx == IDX_LAST) begin
              state_n = RUN;
              ready_n = 1'b1;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      SW_HOLD: begin
        // Lock loss is recorded but the hold always runs to completion
        if (!lock_s) begin
          lock_lost_set = 1'b1;
        end
        if (cnt == HOLD_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n   = WAIT_LOCK;
        cnt_n     = '0;
        idx_n     = '0;
        rst_out_n = '1;
        ready_n   = 1'b0;
      end
    endcase

    // Setting the sticky flag wins over a simultaneous clear
    if (lock_lost_set) begin
      lock_lost_n = 1'b1;
    end else if (clr_lock_lost) begin
      lock_lost_n = 1'b0;
    end else begin
      lock_lost_n = lock_lost;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random lock/request
// traffic, checked against a timestamp-based behavioural model.
module tb_rst_sequencer;

  localparam int N  = 3;
  localparam int D  = 16;
  localparam int LS = 64;
  localparam int SW = 8;

  localparam int PH_WAIT = 0;
  localparam int PH_ACT  = 1;
  localparam int PH_HOLD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, pll_lock, sw_rst_req, clr_lock_lost;
  logic [N-1:0] rst_out;
  logic         ready, lock_lost;

  logic         rst1, pll_lock1, sw_rst_req1, clr_lock_lost1;
  logic [N-1:0] rst_out1;
  logic         ready1, lock_lost1;

  rst_sequencer #(.NUM_STAGES(N), .STAGE_DELAY(D), .LOCK_STABLE(LS),
                  .SW_RST_CYCLES(SW), .USE_LOCK(1)) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .clr_lock_lost(clr_lock_lost), .rst_out(rst_out), .ready(ready),
    .lock_lost(lock_lost)
  );

  rst_sequencer #(.NUM_STAGES(N), .STAGE_DELAY(D), .LOCK_STABLE(LS),
                  .SW_RST_CYCLES(SW), .USE_LOCK(0)) dut_nolock (
    .clk(clk), .rst(rst1), .pll_lock(pll_lock1), .sw_rst_req(sw_rst_req1),
    .clr_lock_lost(clr_lock_lost1), .rst_out(rst_out1), .ready(ready1),
    .lock_lost(lock_lost1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;   // cycle number of the outputs currently visible

  // Reference model: phase plus timestamps of when it was entered
  int           m_t = 0, m_phase = PH_WAIT, m_run = 0, m_act = 0, m_hold = 0;
  bit           m_s1 = 0, m_s2 = 0, m_ll = 0;
  logic [N-1:0] exp_rst_out;
  logic         exp_ready, exp_ll;

  function automatic void model_step();
    bit ls;
    bit set;
    int rel;
    ls   = m_s2;
    set  = 0;
    m_s2 = rst ? 1'b0 : m_s1;
    m_s1 = rst ? 1'b0 : pll_lock;
    if (rst) begin
      m_phase = PH_WAIT;
      m_run   = 0;
      m_ll    = 0;
    end else begin
      case (m_phase)
        PH_WAIT: begin
          if (ls) begin
            m_run++;
            if (m_run == LS) begin
              m_phase = PH_ACT;
              m_act   = m_t + 1;
            end
          end else begin
            m_run = 0;
          end
        end
        PH_ACT: begin
          if (!ls) begin
            m_phase = PH_WAIT;
            m_run   = 0;
            set     = 1;
          end else if (sw_rst_req) begin
            m_phase = PH_HOLD;
            m_hold  = m_t + 1;
          end
        end
        default: begin
          if (!ls) set = 1;
          if (m_t - m_hold == SW - 1) begin
            m_phase = PH_WAIT;
            m_run   = 0;
          end
        end
      endcase
      if (set) m_ll = 1;
      else if (clr_lock_lost) m_ll = 0;
    end
    // Stages released so far = whole STAGE_DELAY periods spent active
    rel = 0;
    if (m_phase == PH_ACT) begin
      rel = (m_t - m_act + 1) / D;
      if (rel > N) rel = N;
    end
    for (int k = 0; k < N; k++) exp_rst_out[k] = (k >= rel);
    exp_ready = (rel == N);
    exp_ll    = m_ll;
    m_t++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    if (rst) cyc = 0;
    else cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; pll_lock = 1; sw_rst_req = 0; clr_lock_lost = 0;
    rst1 = 1; pll_lock1 = 0; sw_rst_req1 = 0; clr_lock_lost1 = 0;
    repeat (3) tick();
    checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL reset_rst_out got %b want 111", rst_out); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
    checks++; if (rst_out1 !== 3'b111 || ready1 !== 1'b0) begin errors++; $display("FAIL reset_nolock got %b/%b want 111/0", rst_out1, ready1); end
  endtask

  task automatic test_release();
    int f[N];
    int rdy;
    for (int k = 0; k < N; k++) f[k] = -1;
    rdy = -1;
    rst = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      checks++;
      if (rst_out !== exp_rst_out || ready !== exp_ready || lock_lost !== exp_ll) begin
        errors++;
        $display("FAIL release_model cyc=%0d got %b %b %b want %b %b %b", cyc, rst_out, ready, lock_lost, exp_rst_out, exp_ready, exp_ll);
      end
      for (int k = 0; k < N; k++) if (f[k] < 0 && rst_out[k] === 1'b0) f[k] = cyc;
      if (rdy < 0 && ready === 1'b1) rdy = cyc;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (f[k] != 82 + k * D) begin errors++; $display("FAIL release_stage%0d cycle got %0d want %0d", k, f[k], 82 + k * D); end
    end
    checks++; if (rdy != 114) begin errors++; $display("FAIL release_ready cycle got %0d want 114", rdy); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL release_lock_lost got %b want 0", lock_lost); end
  endtask

  task automatic test_glitch();
    int f0;
    int rdy;
    f0 = -1; rdy = -1;
    rst = 1; tick(); rst = 0; pll_lock = 1;
    for (int i = 0; i < 170; i++) begin
      if (cyc == 40) pll_lock = 0;
      if (cyc == 43) pll_lock = 1;
      tick();
      checks++;
      if (rst_out !== exp_rst_out || ready !== exp_ready || lock_lost !== exp_ll) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d got %b %b %b want %b %b %b", cyc, rst_out, ready, lock_lost, exp_rst_out, exp_ready, exp_ll);
      end
      if (f0 < 0 && rst_out[0] === 1'b0) f0 = cyc;
      if (rdy < 0 && ready === 1'b1) rdy = cyc;
    end
    checks++; if (f0 != 125) begin errors++; $display("FAIL glitch_stage0 cycle got %0d want 125", f0); end
    checks++; if (rdy != 157) begin errors++; $display("FAIL glitch_ready cycle got %0d want 157", rdy); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL glitch_lock_lost got %b want 0", lock_lost); end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_lock = 0;
    tick(); tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lockloss_early got ready=%b want 1", ready); end
    tick();
    checks++; if (rst_out !== 3'b111 || ready !== 1'b0 || lock_lost !== 1'b1) begin
      errors++; $display("FAIL lockloss_reassert got %b %b %b want 111 0 1", rst_out, ready, lock_lost);
    end
    pll_lock = 1;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      tick(); n++;
      checks++;
      if (rst_out !== exp_rst_out || ready !== exp_ready || lock_lost !== exp_ll) begin
        errors++;
        $display("FAIL relock_model cyc=%0d got %b %b %b want %b %b %b", cyc, rst_out, ready, lock_lost, exp_rst_out, exp_ready, exp_ll);
      end
    end
    checks++; if (n != 2 + LS + N * D) begin errors++; $display("FAIL relock_latency got %0d want %0d", n, 2 + LS + N * D); end
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL relock_sticky got %b want 1", lock_lost); end
    clr_lock_lost = 1; tick(); clr_lock_lost = 0;
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL clr_lock_lost got %b want 0", lock_lost); end
  endtask

  task automatic test_sw_rst();
    int n;
    sw_rst_req = 1; tick(); sw_rst_req = 0;
    checks++; if (rst_out !== 3'b111 || ready !== 1'b0) begin
      errors++; $display("FAIL swrst_reassert got %b %b want 111 0", rst_out, ready);
    end
    n = 0;
    while (rst_out[0] !== 1'b0 && n < 200) begin
      tick(); n++;
      checks++;
      if (rst_out !== exp_rst_out || ready !== exp_ready || lock_lost !== exp_ll) begin
        errors++;
        $display("FAIL swrst_model cyc=%0d got %b %b %b want %b %b %b", cyc, rst_out, ready, lock_lost, exp_rst_out, exp_ready, exp_ll);
      end
    end
    checks++; if (n != SW + LS + D) begin errors++; $display("FAIL swrst_latency got %0d want %0d", n, SW + LS + D); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL swrst_lock_lost got %b want 0", lock_lost); end
  endtask

  task automatic test_collision();
    int n;
    pll_lock = 0;
    tick(); tick();
    sw_rst_req = 1; clr_lock_lost = 1;
    tick();
    sw_rst_req = 0; clr_lock_lost = 0; pll_lock = 1;
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL collide_lock_lost got %b want 1", lock_lost); end
    checks++; if (rst_out !== 3'b111 || ready !== 1'b0) begin errors++; $display("FAIL collide_reassert got %b %b want 111 0", rst_out, ready); end
    n = 0;
    while (rst_out[0] !== 1'b0 && n < 200) begin
      tick(); n++;
      checks++;
      if (rst_out !== exp_rst_out || ready !== exp_ready || lock_lost !== exp_ll) begin
        errors++;
        $display("FAIL collide_model cyc=%0d got %b %b %b want %b %b %b", cyc, rst_out, ready, lock_lost, exp_rst_out, exp_ready, exp_ll);
      end
    end
    // No software hold: requalification starts as soon as lock returns
    checks++; if (n != 2 + LS + D) begin errors++; $display("FAIL collide_latency got %0d want %0d", n, 2 + LS + D); end
  endtask

  task automatic test_rst_mid();
    checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL midrst_pre got %b want 110", rst_out); end
    rst = 1; tick(); rst = 0;
    checks++; if (rst_out !== 3'b111 || ready !== 1'b0 || lock_lost !== 1'b0) begin
      errors++; $display("FAIL midrst_state got %b %b %b want 111 0 0", rst_out, ready, lock_lost);
    end
  endtask

  task automatic test_no_lock();
    int f[N];
    int rdy;
    int e;
    for (int k = 0; k < N; k++) f[k] = -1;
    rdy = -1; e = 0;
    rst1 = 0; pll_lock1 = 0;
    for (int i = 0; i < 120; i++) begin
      tick(); e++;
      for (int k = 0; k < N; k++) if (f[k] < 0 && rst_out1[k] === 1'b0) f[k] = e;
      if (rdy < 0 && ready1 === 1'b1) rdy = e;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (f[k] != 80 + k * D) begin errors++; $display("FAIL nolock_stage%0d cycle got %0d want %0d", k, f[k], 80 + k * D); end
    end
    checks++; if (rdy != 112) begin errors++; $display("FAIL nolock_ready cycle got %0d want 112", rdy); end
    checks++; if (lock_lost1 !== 1'b0) begin errors++; $display("FAIL nolock_lock_lost got %b want 0", lock_lost1); end
  endtask

  task automatic test_random();
    int low_left;
    low_left = 0;
    rst = 1; tick(); rst = 0; pll_lock = 1;
    for (int i = 0; i < 4000; i++) begin
      if (low_left > 0) begin
        low_left--;
        pll_lock = (low_left == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        low_left = $urandom_range(1, 6);
        pll_lock = 0;
      end
      sw_rst_req    = ($urandom_range(0, 199) == 0);
      clr_lock_lost = ($urandom_range(0, 49) == 0);
      rst           = ($urandom_range(0, 1999) == 0);
      tick();
      checks++;
      if (rst_out !== exp_rst_out || ready !== exp_ready || lock_lost !== exp_ll) begin
        errors++;
        $display("FAIL random_model i=%0d got %b %b %b want %b %b %b", i, rst_out, ready, lock_lost, exp_rst_out, exp_ready, exp_ll);
      end
    end
    rst = 0; sw_rst_req = 0; clr_lock_lost = 0; pll_lock = 1;
  endtask

  initial begin
    test_reset();
    test_release();
    test_glitch();
    test_lock_loss();
    test_sw_rst();
    test_collision();
    test_rst_mid();
    test_no_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
